ram_sync_clr: RTL and testbench
===============================

# ram_sync_clr

Parametrised synchronous RAM with one write port and one read port. It is the next-generation data store for the small register/RAM blocks in the design. It adds a bit-level write mask, a registered read with a valid flag, and write-first bypass. A hardware clear sequencer zeroes every word after reset or on request and reports progress through `busy`. The block sits between a simple request master (address / enable / data) and any consumer that samples `rd` when `rvalid` is high.

## Interface
Parameters:
- `DATA_W`, default 4: word width in bits.
- `ADDR_W`, default 4: address width. Depth is `DEPTH = 2**ADDR_W`.

Ports:
- `clock`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `clr`  in  1: clear request, sampled only when not busy.
- `we`  in  1: write enable.
- `wa`  in  `ADDR_W`: write address.
- `wd`  in  `DATA_W`: write data.
- `wm`  in  `DATA_W`: write bit mask (1 = bit is written).
- `re`  in  1: read enable.
- `ra`  in  `ADDR_W`: read address.
- `rd`  out  `DATA_W`: registered read data.
- `rvalid`  out  1: `rd` updated this cycle.
- `busy`  out  1: clear sweep in progress; requests are ignored.
- `drop`  out  1: one-cycle pulse, a `we` or `re` was ignored because `busy` was high.

## Operation
- FSM states:
  - CLEAR: sweeps the array. `busy` = 1.
  - RUN: normal access. `busy` = 0.
- `busy`, `rvalid`, `rd` and `drop` are all registered.
- Reset (edge with `reset` = 1):
  - state ← CLEAR, sweep pointer `ptr` ← 0.
  - `busy` = 1, `rvalid` = 0, `rd` = 0, `drop` = 0.
  - Array contents are not reset directly; the sweep clears them.
- CLEAR, each edge:
  - mem[`ptr`] ← 0, then `ptr` ← `ptr` + 1.
  - On the edge that writes `DEPTH`-1: state ← RUN, `busy` ← 0, `ptr` wraps to 0.
- CLEAR, other behaviour:
  - `we` and `re` are ignored. `rvalid` ← 0. `drop` ← (`we` | `re`).
  - `clr` is ignored; it does not restart the sweep.
- RUN, write: if `we`, mem[`wa`] ← (mem[`wa`] & ~`wm`) | (`wd` & `wm`). `wm` = 0 is a legal no-op write.
- RUN, read:
  - If `re`: `rd` ← mem[`ra`] and `rvalid` ← 1.
  - Otherwise `rvalid` ← 0 and `rd` holds its previous value.
- RUN, read-during-write: if `we` & `re` & (`wa` == `ra`), `rd` ← the merged new word (write-first bypass).
- RUN, `clr` = 1:
  - `we`/`re` in the same cycle are still performed.
  - state ← CLEAR, `ptr` ← 0, `busy` ← 1 on that edge.
  - The sweep then zeroes everything, including that same-cycle write.
- Priority: `reset` > sweep > user requests.
- Reset asserted mid-sweep restarts the sweep from address 0.
- Widths: addresses are unsigned. `ptr` is `ADDR_W` bits and wraps naturally. No out-of-range addresses exist.

## Timing
- Read latency is 1 cycle: `re` sampled at edge N gives `rd` and `rvalid` valid after edge N.
- `rvalid` is high for exactly one cycle per accepted read. Back-to-back reads give continuous `rvalid`.
- After reset: the first edge with `reset` = 0 writes address 0. `busy` falls after edge `DEPTH` counted from release, i.e. 16 edges at the default parameters. The first request is accepted on edge `DEPTH`+1.
- `clr` accepted at edge N: `busy` is high after edge N through edge N+`DEPTH`. Requests are accepted again from edge N+`DEPTH`+1.
- `drop` is asserted in the cycle after the ignored request and lasts one cycle per ignored cycle.
- Writes take effect at the edge. A read of the same address on the following edge returns the new data.

## Test plan
Defaults apply (`DATA_W` = 4, `ADDR_W` = 4).
1. Reset sequence:
   - Stimulus: `reset` high 2 cycles, then low; count edges.
   - Required: `busy` = 1 for exactly 16 edges, then 0. Read `ra` = 5 returns `rd` = 0000 with `rvalid` = 1 one cycle later.
2. Basic write/read:
   - Stimulus: write `wa` = 2, `wd` = 1101, `wm` = 1111; next cycle read `ra` = 2.
   - Required: `rd` = 1101 with `rvalid` = 1. `rvalid` = 0 on the cycle after.
3. Masked write:
   - Stimulus: address 2 holds 1101; write `wd` = 0010, `wm` = 0011; then read address 2.
   - Required: `rd` = 1110.
4. Read-during-write:
   - Stimulus: same cycle `we` with `wa` = 7, `wd` = 1010, `wm` = 1111, and `re` with `ra` = 7.
   - Required: next cycle `rd` = 1010, `rvalid` = 1.
5. Clear and drop:
   - Stimulus: with addresses 2 and 7 written, pulse `clr`; next cycle assert `we` to address 3.
   - Required: `busy` = 1 for 16 cycles. `drop` pulses once and `rvalid` stays 0. After the sweep, addresses 2, 3 and 7 all read 0000.
6. Reset mid-sweep:
   - Stimulus: assert `reset` during cycle 5 of a clear sweep.
   - Required: `busy` stays 1. Exactly 16 edges after release `busy` = 0. `rd` = 0 and `rvalid` = 0 throughout the reset cycle.

Source files
------------

// File: rtl/ram_sync_clr.sv
// Synchronous 1W/1R RAM with bit-masked writes, registered read with valid flag,
// write-first bypass and a hardware clear sweep that runs after reset or on request.
module ram_sync_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] wm,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd,
  output logic              rvalid,
  output logic              busy,
  output logic              drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_rd;
  logic              r_rvalid;
  logic              r_busy;
  logic              r_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_merged;
  logic              w_bypass;

  // Merged word for a masked write; also the value forwarded on a same-address read.
  assign w_merged = (r_mem[wa] & ~wm) | (wd & wm);
  assign w_bypass = we && (wa == ra);

  // NOTE: the array has no reset branch so it can map onto RAM macros; the sweep zeroes it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_ptr] <= '0;
      end else if (we) begin
        r_mem[wa] <= w_merged;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= CLEAR;
      r_ptr    <= '0;
      r_busy   <= 1'b1;
      r_rvalid <= 1'b0;
      r_rd     <= '0;
      r_drop   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_ptr    <= r_ptr + ADDR_W'(1);
          r_rvalid <= 1'b0;
          r_drop   <= we | re;
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_drop <= 1'b0;
          if (re) begin
            r_rd     <= w_bypass ? w_merged : r_mem[ra];
            r_rvalid <= 1'b1;
          end else begin
            r_rvalid <= 1'b0;
          end
          // Same-cycle requests still complete; the sweep then overwrites them.
          if (clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign rd     = r_rd;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;
  assign drop   = r_drop;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed self-checking bench for ram_sync_clr at default parameters (4-bit data, 16 words).
module tb_ram_sync_clr;

  logic       clock;
  logic       reset;
  logic       clr;
  logic       we;
  logic [3:0] wa;
  logic [3:0] wd;
  logic [3:0] wm;
  logic       re;
  logic [3:0] ra;
  logic [3:0] rd;
  logic       rvalid;
  logic       busy;
  logic       drop;

  int n_checks = 0;
  int n_errors = 0;

  ram_sync_clr #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .wm     (wm),
    .re     (re),
    .ra     (ra),
    .rd     (rd),
    .rvalid (rvalid),
    .busy   (busy),
    .drop   (drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; re = 1'b0;
    wa = '0; wd = '0; wm = '0; ra = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;

    // 1. Reset sequence
    step();
    step();
    check("rst_busy", 8'(busy), 8'h1);
    check("rst_rvalid", 8'(rvalid), 8'h0);
    check("rst_rd", 8'(rd), 8'h0);
    check("rst_drop", 8'(drop), 8'h0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("init_busy_e%0d", i), 8'(busy), (i < 16) ? 8'h1 : 8'h0);
    end
    re = 1'b1; ra = 4'd5;
    step();
    check("init_rd5", 8'(rd), 8'h0);
    check("init_rv5", 8'(rvalid), 8'h1);

    // 2. Basic write/read
    idle(); we = 1'b1; wa = 4'd2; wd = 4'b1101; wm = 4'b1111;
    step();
    check("wr_rvalid", 8'(rvalid), 8'h0);
    idle(); re = 1'b1; ra = 4'd2;
    step();
    check("rd2", 8'(rd), 8'hD);
    check("rd2_rv", 8'(rvalid), 8'h1);
    idle();
    step();
    check("rd2_rv_after", 8'(rvalid), 8'h0);
    check("rd2_hold", 8'(rd), 8'hD);

    // 3. Masked write, then a zero-mask write that must change nothing
    idle(); we = 1'b1; wa = 4'd2; wd = 4'b0010; wm = 4'b0011;
    step();
    idle(); we = 1'b1; wa = 4'd2; wd = 4'b1111; wm = 4'b0000;
    step();
    idle(); re = 1'b1; ra = 4'd2;
    step();
    check("mask_rd2", 8'(rd), 8'hE);

    // 4. Read-during-write bypass, full and partial mask
    idle(); we = 1'b1; wa = 4'd7; wd = 4'b1010; wm = 4'b1111; re = 1'b1; ra = 4'd7;
    step();
    check("byp_rd", 8'(rd), 8'hA);
    check("byp_rv", 8'(rvalid), 8'h1);
    idle(); we = 1'b1; wa = 4'd7; wd = 4'b0101; wm = 4'b0011; re = 1'b1; ra = 4'd7;
    step();
    check("byp_mask_rd", 8'(rd), 8'h9);
    idle(); re = 1'b1; ra = 4'd2;
    step();
    check("b2b_rd2", 8'(rd), 8'hE);
    check("b2b_rv2", 8'(rvalid), 8'h1);
    ra = 4'd7;
    step();
    check("b2b_rd7", 8'(rd), 8'h9);
    check("b2b_rv7", 8'(rvalid), 8'h1);

    // 5. Clear with same-cycle write+read, then a dropped write
    idle(); clr = 1'b1; we = 1'b1; wa = 4'd9; wd = 4'b1111; wm = 4'b1111;
    re = 1'b1; ra = 4'd2;
    step();
    check("clr_busy", 8'(busy), 8'h1);
    check("clr_same_rd", 8'(rd), 8'hE);
    check("clr_same_rv", 8'(rvalid), 8'h1);
    idle(); we = 1'b1; wa = 4'd3; wd = 4'b1111; wm = 4'b1111;
    step();
    check("drop_pulse", 8'(drop), 8'h1);
    check("drop_rv", 8'(rvalid), 8'h0);
    check("drop_busy", 8'(busy), 8'h1);
    idle();
    step();
    check("drop_end", 8'(drop), 8'h0);
    for (int k = 3; k <= 16; k++) begin
      step();
      check($sformatf("clr_busy_e%0d", k), 8'(busy), (k < 16) ? 8'h1 : 8'h0);
      check($sformatf("clr_rv_e%0d", k), 8'(rvalid), 8'h0);
    end
    re = 1'b1;
    ra = 4'd2; step(); check("clr_rd2", 8'(rd), 8'h0); check("clr_rv2", 8'(rvalid), 8'h1);
    ra = 4'd3; step(); check("clr_rd3", 8'(rd), 8'h0);
    ra = 4'd7; step(); check("clr_rd7", 8'(rd), 8'h0);
    ra = 4'd9; step(); check("clr_rd9", 8'(rd), 8'h0);

    // 6. Reset in the middle of a sweep
    idle(); we = 1'b1; wa = 4'd4; wd = 4'b0110; wm = 4'b1111;
    step();
    idle(); re = 1'b1; ra = 4'd4;
    step();
    check("pre_rd4", 8'(rd), 8'h6);
    idle(); clr = 1'b1;
    step();
    idle(); we = 1'b1; wa = 4'd1;
    for (int k = 1; k <= 4; k++) step();
    reset = 1'b1;
    step();
    check("mid_rst_busy", 8'(busy), 8'h1);
    check("mid_rst_rd", 8'(rd), 8'h0);
    check("mid_rst_rv", 8'(rvalid), 8'h0);
    check("mid_rst_drop", 8'(drop), 8'h0);
    reset = 1'b0; idle();
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("mid_busy_e%0d", i), 8'(busy), (i < 16) ? 8'h1 : 8'h0);
    end
    re = 1'b1; ra = 4'd4;
    step();
    check("mid_rd4", 8'(rd), 8'h0);
    check("mid_rv4", 8'(rvalid), 8'h1);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
